flu_edit_insert_4b: RTL and testbench
=====================================

// Module: flu_edit_insert_4b
// PURPOSE
//  Overwrites 4 consecutive bytes of each FLU packet with a 32-bit value from a
//  per-packet edit header, at a byte offset relative to packet start.
//  Write-side counterpart of the 4-byte extractor in comp/flu_tools/edit.
//  Sits inline on a FLU stream. Packet length and framing are never changed.
// PARAMETERS
//  DATA_WIDTH     512   FLU data width in bits (WB = DATA_WIDTH/8 bytes per word)
//  SOP_POS_WIDTH  3     SOP position width; SOP granularity G = WB/2**SOP_POS_WIDTH bytes
//  EOP_POS_WIDTH  log2(DATA_WIDTH/8)  EOP byte position width
//  OFFSET_WIDTH   10    width of edit byte offset
//  INPUT_PIPE     TRUE  adds one register stage on RX before edit logic
// PORTS
//  CLK          in   1             clock
//  RESET        in   1             asynchronous, active-high reset
//  RX_DATA      in   DATA_WIDTH    FLU input data; byte k = bits 8k+7:8k
//  RX_SOP_POS   in   SOP_POS_WIDTH SOP block index
//  RX_EOP_POS   in   EOP_POS_WIDTH last valid byte index
//  RX_SOP       in   1             word contains packet start
//  RX_EOP       in   1             word contains packet end
//  RX_SRC_RDY   in   1             RX word valid
//  RX_DST_RDY   out  1             RX word accepted
//  HDR_DATA     in   32            replacement bytes; byte k goes to packet byte OFFSET+k
//  HDR_OFFSET   in   OFFSET_WIDTH  byte offset from packet's first byte
//  HDR_EN       in   1             0 = pass packet unmodified
//  HDR_SRC_RDY  in   1             header valid
//  HDR_DST_RDY  out  1             header consumed
//  TX_DATA/TX_SOP_POS/TX_EOP_POS/TX_SOP/TX_EOP  out  (same widths)  FLU output
//  TX_SRC_RDY   out  1             TX word valid
//  TX_DST_RDY   in   1             TX word accepted
// BEHAVIOUR
//  - Reset (async): TX_SRC_RDY=0, TX_SOP=0, TX_EOP=0, TX_DATA=0, positions=0.
//    Internal counter, edit regs and in_pkt flag are cleared. HDR_DST_RDY=0.
//    A packet interrupted by reset is lost. Words arriving later with no open
//    SOP are forwarded unedited.
//  - Output register: ordinary valid/ready stage; out_rdy = ~TX_SRC_RDY | TX_DST_RDY.
//    Latency RX accept -> TX valid is 1 cycle, or 2 cycles with INPUT_PIPE.
//    Full throughput: 1 word/cycle.
//  - Header handshake: one header per packet, taken on the cycle the SOP word is accepted.
//    RX_DST_RDY  = out_rdy & (~RX_SOP | HDR_SRC_RDY)
//    HDR_DST_RDY = out_rdy & RX_SRC_RDY & RX_SOP & HDR_SRC_RDY
//    SOP word with no header ready: stall, nothing consumed.
//    Header with no SOP word: waits.
//  - Byte counter CNT, OFFSET_WIDTH+1 bits, holds the packet-relative index of
//    byte 0 of the next word.
//    SOP word: CNT <= WB - SOP_POS*G.
//    Non-SOP word in packet: CNT <= CNT+WB, saturating at all-ones.
//  - Packet-relative index r of byte j:
//    continuing packet: r = CNT + j
//    new packet (j >= SOP_POS*G): r = j - SOP_POS*G
//  - Byte j is replaced with HDR byte (r-OFFSET) when 0 <= r-OFFSET <= 3,
//    the edit is enabled, and the byte lies inside the packet.
//    Bytes after EOP or before SOP in a word are never modified.
//    Edits may straddle a word boundary.
//  - Shared word (EOP of A and SOP of B, SOP_POS*G > EOP_POS):
//    bytes <= EOP_POS use A's latched edit regs;
//    bytes >= SOP_POS*G use B's header straight from the HDR_* inputs.
//  - Offsets beyond packet length: no modification, no error.
//  - HDR_EN, HDR_DATA and HDR_OFFSET are latched at SOP accept; the latched
//    values are used for the rest of that packet.
//  - All control fields (SOP/EOP/positions) pass through bit-exact.
// TESTING  (DATA_WIDTH=512: WB=64, G=8)
//  1. SOP_POS=0, OFFSET=0, HDR_DATA=0xDDCCBBAA, EN=1
//     -> TX bytes0..3 = AA,BB,CC,DD, rest equal RX; TX valid 1 cycle after accept (INPUT_PIPE=FALSE).
//  2. SOP_POS=0, OFFSET=62, 128B packet
//     -> word0 bytes62,63 = AA,BB; word1 bytes0,1 = CC,DD.
//  3. HDR_EN=0, 200B random packet -> output bit-identical to input.
//  4. Shared word: A EOP_POS=20; B SOP_POS=4, B OFFSET=2
//     -> bytes34..37 get B data; bytes 0..20 follow A rules; bytes 21..31 unchanged.
//  5. SOP word present, HDR_SRC_RDY=0 for 5 cycles
//     -> RX_DST_RDY=0 and HDR_DST_RDY=0 throughout; after header arrives, packet edited correctly.
//  6. OFFSET=1000 on 128B packets; random TX_DST_RDY (50%); RESET mid-packet
//     -> no change and no word loss/duplication; TX_SRC_RDY=0 immediately on RESET.

Source files
------------

// File: rtl/flu_edit_insert_4b.sv
// Inline FLU stage that overwrites four consecutive packet bytes with a per-packet
// 32-bit header value at a packet-relative byte offset; framing passes through untouched.
module flu_edit_insert_4b #(
    parameter int DATA_WIDTH    = 512,
    parameter int SOP_POS_WIDTH = 3,
    parameter int EOP_POS_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int OFFSET_WIDTH  = 10,
    parameter bit INPUT_PIPE    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic [SOP_POS_WIDTH-1:0] rx_sop_pos,
    input  logic [EOP_POS_WIDTH-1:0] rx_eop_pos,
    input  logic                     rx_sop,
    input  logic                     rx_eop,
    input  logic                     rx_src_rdy,
    output logic                     rx_dst_rdy,
    input  logic [31:0]              hdr_data,
    input  logic [OFFSET_WIDTH-1:0]  hdr_offset,
    input  logic                     hdr_en,
    input  logic                     hdr_src_rdy,
    output logic                     hdr_dst_rdy,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic [SOP_POS_WIDTH-1:0] tx_sop_pos,
    output logic [EOP_POS_WIDTH-1:0] tx_eop_pos,
    output logic                     tx_sop,
    output logic                     tx_eop,
    output logic                     tx_src_rdy,
    input  logic                     tx_dst_rdy
);

    localparam int WB = DATA_WIDTH / 8;
    localparam int G  = WB >> SOP_POS_WIDTH;
    localparam int CW = OFFSET_WIDTH + 1;
    localparam int RW = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]    e_data;
    logic [SOP_POS_WIDTH-1:0] e_sop_pos;
    logic [EOP_POS_WIDTH-1:0] e_eop_pos;
    logic                     e_sop;
    logic                     e_eop;
    logic                     e_vld;
    logic                     e_rdy;
    logic                     e_take;
    logic                     out_rdy;

    logic [CW-1:0]            cnt;
    logic                     in_pkt;
    logic                     en_q;
    logic [31:0]              data_q;
    logic [OFFSET_WIDTH-1:0]  off_q;

    logic [RW-1:0]            sop_byte;
    logic [RW-1:0]            eop_w;
    logic [RW-1:0]            jw;
    logic                     new_ends_here;
    logic                     old_ends_here;
    logic [DATA_WIDTH-1:0]    edit_data;

    function automatic logic in_window(input logic [RW-1:0] r, input logic [OFFSET_WIDTH-1:0] off);
        return (r >= RW'(off)) && ((r - RW'(off)) < RW'(4));
    endfunction

    function automatic logic [1:0] win_idx(input logic [RW-1:0] r, input logic [OFFSET_WIDTH-1:0] off);
        logic [RW-1:0] d;
        d = r - RW'(off);
        return d[1:0];
    endfunction

    // Reset also blocks both handshakes so nothing is consumed while the stage is cleared.
    assign out_rdy     = ~reset & (~tx_src_rdy | tx_dst_rdy);
    assign e_rdy       = out_rdy & (~e_sop | hdr_src_rdy);
    assign e_take      = e_vld & e_rdy;
    assign hdr_dst_rdy = out_rdy & e_vld & e_sop & hdr_src_rdy;

    generate
        if (INPUT_PIPE) begin : g_pipe
            logic [DATA_WIDTH-1:0]    p_data;
            logic [SOP_POS_WIDTH-1:0] p_sop_pos;
            logic [EOP_POS_WIDTH-1:0] p_eop_pos;
            logic                     p_sop;
            logic                     p_eop;
            logic                     p_vld;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p_vld     <= 1'b0;
                    p_data    <= '0;
                    p_sop_pos <= '0;
                    p_eop_pos <= '0;
                    p_sop     <= 1'b0;
                    p_eop     <= 1'b0;
                end else if (rx_dst_rdy) begin
                    p_vld <= rx_src_rdy;
                    if (rx_src_rdy) begin
                        p_data    <= rx_data;
                        p_sop_pos <= rx_sop_pos;
                        p_eop_pos <= rx_eop_pos;
                        p_sop     <= rx_sop;
                        p_eop     <= rx_eop;
                    end
                end
            end

            assign rx_dst_rdy = ~reset & (~p_vld | e_rdy);
            assign e_vld      = p_vld;
            assign e_data     = p_data;
            assign e_sop_pos  = p_sop_pos;
            assign e_eop_pos  = p_eop_pos;
            assign e_sop      = p_sop;
            assign e_eop      = p_eop;
        end else begin : g_nopipe
            assign rx_dst_rdy = e_rdy;
            assign e_vld      = rx_src_rdy;
            assign e_data     = rx_data;
            assign e_sop_pos  = rx_sop_pos;
            assign e_eop_pos  = rx_eop_pos;
            assign e_sop      = rx_sop;
            assign e_eop      = rx_eop;
        end
    endgenerate

    // A word carrying SOP and an EOP at or after it holds a whole packet; otherwise the EOP closes the old one.
    assign sop_byte      = RW'(e_sop_pos) * RW'(G);
    assign eop_w         = RW'(e_eop_pos);
    assign new_ends_here = e_sop & e_eop & (eop_w >= sop_byte);
    assign old_ends_here = e_eop & ~new_ends_here;

    always_comb begin
        edit_data = e_data;
        jw        = '0;
        for (int j = 0; j < WB; j++) begin
            jw = RW'(j);
            if (in_pkt && en_q && (old_ends_here ? (jw <= eop_w) : (!e_sop || jw < sop_byte))
                && in_window(RW'(cnt) + jw, off_q))
                edit_data[8*j +: 8] = data_q[8*win_idx(RW'(cnt) + jw, off_q) +: 8];
            // The new packet's edit comes straight from the header inputs, which are being consumed now.
            if (e_sop && hdr_en && jw >= sop_byte && (!new_ends_here || jw <= eop_w)
                && in_window(jw - sop_byte, hdr_offset))
                edit_data[8*j +: 8] = hdr_data[8*win_idx(jw - sop_byte, hdr_offset) +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            in_pkt <= 1'b0;
            en_q   <= 1'b0;
            data_q <= '0;
            off_q  <= '0;
        end else if (e_take) begin
            if (e_sop) begin
                cnt    <= CW'(WB) - CW'(sop_byte);
                in_pkt <= ~new_ends_here;
                en_q   <= hdr_en;
                data_q <= hdr_data;
                off_q  <= hdr_offset;
            end else if (in_pkt) begin
                cnt <= (cnt > CNT_MAX - CW'(WB)) ? CNT_MAX : cnt + CW'(WB);
                if (e_eop)
                    in_pkt <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_src_rdy <= 1'b0;
            tx_data    <= '0;
            tx_sop_pos <= '0;
            tx_eop_pos <= '0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
        end else if (out_rdy) begin
            tx_src_rdy <= e_take;
            if (e_take) begin
                tx_data    <= edit_data;
                tx_sop_pos <= e_sop_pos;
                tx_eop_pos <= e_eop_pos;
                tx_sop     <= e_sop;
                tx_eop     <= e_eop;
            end
        end
    end

endmodule

// File: tb/tb_flu_edit_insert_4b.sv
// Bench for flu_edit_insert_4b: packets are edited at packet level, laid out into
// FLU words and compared word by word against the DUT output stream.
module tb_flu_edit_insert_4b;

    localparam int DW = 512;
    localparam int WB = 64;
    localparam int G  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic [2:0]    rx_sop_pos;
    logic [5:0]    rx_eop_pos;
    logic          rx_sop, rx_eop, rx_src_rdy, rx_dst_rdy;
    logic [31:0]   hdr_data;
    logic [9:0]    hdr_offset;
    logic          hdr_en, hdr_src_rdy, hdr_dst_rdy;
    logic [DW-1:0] tx_data;
    logic [2:0]    tx_sop_pos;
    logic [5:0]    tx_eop_pos;
    logic          tx_sop, tx_eop, tx_src_rdy, tx_dst_rdy;

    always #5 clk = ~clk;

    flu_edit_insert_4b #(
        .DATA_WIDTH(DW), .SOP_POS_WIDTH(3), .EOP_POS_WIDTH(6),
        .OFFSET_WIDTH(10), .INPUT_PIPE(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_sop_pos(rx_sop_pos), .rx_eop_pos(rx_eop_pos),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_src_rdy(rx_src_rdy), .rx_dst_rdy(rx_dst_rdy),
        .hdr_data(hdr_data), .hdr_offset(hdr_offset), .hdr_en(hdr_en),
        .hdr_src_rdy(hdr_src_rdy), .hdr_dst_rdy(hdr_dst_rdy),
        .tx_data(tx_data), .tx_sop_pos(tx_sop_pos), .tx_eop_pos(tx_eop_pos),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_src_rdy(tx_src_rdy), .tx_dst_rdy(tx_dst_rdy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [2:0]    sp;
        logic [5:0]    ep;
    } word_t;

    typedef struct {
        int          len;
        int          sblk;
        int          off;
        logic [31:0] hdr;
        logic        en;
        int          base;
    } pkt_t;

    typedef struct packed {
        int             len;
        int             sblk;
        int             off;
        logic [31:0]    hdr;
        logic           en;
        logic [3:0][7:0] ppos;
        logic [3:0][7:0] pval;
    } vec_t;

    pkt_t        pkts[$];
    pkt_t        hdrQ[$];
    logic [7:0]  byteStore[$];
    word_t       rxWords[$];
    word_t       expWords[$];
    word_t       txGot[$];
    vec_t        vecs[8];
    int          rxIdx, hdrIdx, expIdx;
    bit          rxActive, hdrActive;
    int          testsRun, testsFailed;

    function automatic word_t fillWord(input bit randFill);
        word_t w;
        w = '0;
        for (int b = 0; b < WB; b++)
            w.data[8*b +: 8] = randFill ? 8'($urandom) : 8'hEE;
        return w;
    endfunction

    function automatic vec_t mkVec(input int len, input int sblk, input int off, input logic [31:0] hdr,
                                   input logic en, input logic [31:0] pos, input logic [31:0] val);
        vec_t v;
        v.len = len; v.sblk = sblk; v.off = off; v.hdr = hdr; v.en = en;
        v.ppos = pos; v.pval = val;
        return v;
    endfunction

    task automatic clearAll();
        pkts.delete(); hdrQ.delete(); rxWords.delete(); expWords.delete(); txGot.delete();
        rxIdx = 0; hdrIdx = 0; expIdx = 0; rxActive = 0; hdrActive = 0;
    endtask

    task automatic addPkt(input int len, input int sblk, input int off, input logic [31:0] hdr,
                          input logic en, input bit det);
        pkt_t p;
        p.len = len; p.sblk = sblk; p.off = off; p.hdr = hdr; p.en = en; p.base = byteStore.size();
        for (int i = 0; i < len; i++)
            byteStore.push_back(det ? 8'(i) : 8'($urandom));
        pkts.push_back(p);
    endtask

    // Packet-level edit (bytes off..off+3 inside the packet), then lay packets into FLU words.
    task automatic buildStream(input bit randFill);
        word_t      cur, curE;
        pkt_t       p;
        bit         open, hasSop, share;
        int         pos, sb;
        logic [7:0] b, e;
        open = 0; hasSop = 0; pos = 0;
        cur = '0; curE = '0;
        foreach (pkts[pi]) begin
            p = pkts[pi];
            sb = p.sblk * G;
            share = open && !hasSop && (sb >= pos) && (p.len > WB - sb);
            if (open && !share) begin
                rxWords.push_back(cur); expWords.push_back(curE); open = 0;
            end
            if (!open) begin
                cur = fillWord(randFill); curE = cur; open = 1; hasSop = 0;
            end
            cur.sop = 1'b1; cur.sp = 3'(p.sblk); curE.sop = 1'b1; curE.sp = 3'(p.sblk);
            hasSop = 1; pos = sb;
            hdrQ.push_back(p);
            for (int i = 0; i < p.len; i++) begin
                if (pos == WB) begin
                    rxWords.push_back(cur); expWords.push_back(curE);
                    cur = fillWord(randFill); curE = cur; hasSop = 0; pos = 0;
                end
                b = byteStore[p.base + i];
                e = b;
                for (int k = 0; k < 4; k++)
                    if (p.en && (p.off + k == i)) e = p.hdr[8*k +: 8];
                cur.data[8*pos +: 8] = b;
                curE.data[8*pos +: 8] = e;
                pos++;
            end
            cur.eop = 1'b1; cur.ep = 6'(pos - 1); curE.eop = 1'b1; curE.ep = 6'(pos - 1);
        end
        if (open) begin
            rxWords.push_back(cur); expWords.push_back(curE);
        end
        pkts.delete();
    endtask

    task automatic checkSignal(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput();
        word_t got;
        got = {tx_data, tx_sop, tx_eop, tx_sop_pos, tx_eop_pos};
        testsRun++;
        if (got !== expWords[expIdx]) begin
            testsFailed++;
            $display("[TB] FAIL tx_word[%0d]: got sop=%b eop=%b sp=%0d ep=%0d data=%h, required sop=%b eop=%b sp=%0d ep=%0d data=%h",
                     expIdx, got.sop, got.eop, got.sp, got.ep, got.data, expWords[expIdx].sop,
                     expWords[expIdx].eop, expWords[expIdx].sp, expWords[expIdx].ep, expWords[expIdx].data);
        end
        txGot.push_back(got);
        expIdx++;
    endtask

    // Drive RX words and headers with random gaps, random TX backpressure; bounded by cycle budget.
    task automatic applyStimulus(input int rxPct, input int hdrPct, input int txPct, input int budget,
                                 output int cycles);
        int extra;
        cycles = 0;
        while (expIdx < expWords.size() && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (!rxActive && rxIdx < rxWords.size() && $urandom_range(99) < rxPct) rxActive = 1;
            if (rxActive) begin
                rx_data = rxWords[rxIdx].data; rx_sop = rxWords[rxIdx].sop; rx_eop = rxWords[rxIdx].eop;
                rx_sop_pos = rxWords[rxIdx].sp; rx_eop_pos = rxWords[rxIdx].ep; rx_src_rdy = 1'b1;
            end else
                rx_src_rdy = 1'b0;
            if (!hdrActive && hdrIdx < hdrQ.size() && $urandom_range(99) < hdrPct) hdrActive = 1;
            if (hdrActive) begin
                hdr_data = hdrQ[hdrIdx].hdr; hdr_offset = 10'(hdrQ[hdrIdx].off);
                hdr_en = hdrQ[hdrIdx].en; hdr_src_rdy = 1'b1;
            end else begin
                hdr_src_rdy = 1'b0; hdr_data = $urandom;
            end
            tx_dst_rdy = ($urandom_range(99) < txPct);
            #4;
            if (rx_src_rdy && rx_dst_rdy) begin rxIdx++; rxActive = 0; end
            if (hdr_src_rdy && hdr_dst_rdy) begin hdrIdx++; hdrActive = 0; end
            if (tx_src_rdy && tx_dst_rdy) checkOutput();
        end
        if (expIdx < expWords.size()) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL stream_timeout: got %0d words, required %0d", expIdx, expWords.size());
        end
        @(negedge clk);
        rx_src_rdy = 1'b0; hdr_src_rdy = 1'b0; tx_dst_rdy = 1'b1;
        extra = 0;
        repeat (3) begin
            #4;
            if (tx_src_rdy) extra++;
            @(negedge clk);
        end
        checkSignal("extra_tx_words", DW'(extra), DW'(0));
        checkSignal("headers_consumed", DW'(hdrIdx), DW'(hdrQ.size()));
    endtask

    initial begin
        int         cyc, w, b;
        int         nWords;
        word_t      stray;
        logic [31:0] hdrA, hdrB;
        testsRun = 0; testsFailed = 0;
        reset = 1'b0; rx_src_rdy = 0; rx_sop = 0; rx_eop = 0; rx_data = '0; rx_sop_pos = '0; rx_eop_pos = '0;
        hdr_src_rdy = 0; hdr_data = '0; hdr_offset = '0; hdr_en = 0; tx_dst_rdy = 0;
        clearAll();

        vecs[0] = mkVec(64,  0, 0,    32'hDDCCBBAA, 1, {8'd4,  8'd3,  8'd1,  8'd0},  {8'h04, 8'hDD, 8'hBB, 8'hAA});
        vecs[1] = mkVec(128, 0, 62,   32'hDDCCBBAA, 1, {8'd65, 8'd64, 8'd63, 8'd62}, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
        vecs[2] = mkVec(100, 0, 5,    32'h11223344, 0, {8'd99, 8'd0,  8'd8,  8'd5},  {8'h63, 8'h00, 8'h08, 8'h05});
        vecs[3] = mkVec(40,  2, 3,    32'h44332211, 1, {8'd23, 8'd15, 8'd22, 8'd19}, {8'h07, 8'hEE, 8'h44, 8'h11});
        vecs[4] = mkVec(30,  0, 28,   32'hDDCCBBAA, 1, {8'd31, 8'd30, 8'd29, 8'd28}, {8'hEE, 8'hEE, 8'hBB, 8'hAA});
        vecs[5] = mkVec(128, 0, 1000, 32'hDDCCBBAA, 1, {8'd127,8'd64, 8'd63, 8'd0},  {8'h7F, 8'h40, 8'h3F, 8'h00});
        vecs[6] = mkVec(20,  7, 6,    32'hDDCCBBAA, 1, {8'd65, 8'd64, 8'd63, 8'd62}, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
        vecs[7] = mkVec(64,  0, 61,   32'hDDCCBBAA, 1, {8'd0,  8'd60, 8'd63, 8'd61}, {8'h00, 8'h3C, 8'hCC, 8'hAA});

        // Reset state
        #1 reset = 1'b1;
        #1;
        checkSignal("reset_tx_src_rdy", DW'(tx_src_rdy), DW'(0));
        checkSignal("reset_tx_data", tx_data, '0);
        checkSignal("reset_tx_ctrl", DW'({tx_sop, tx_eop, tx_sop_pos, tx_eop_pos}), DW'(0));
        checkSignal("reset_hdr_dst_rdy", DW'(hdr_dst_rdy), DW'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Table-driven single packets with hand-derived probe bytes
        for (int v = 0; v < 8; v++) begin
            clearAll();
            addPkt(vecs[v].len, vecs[v].sblk, vecs[v].off, vecs[v].hdr, vecs[v].en, 1);
            buildStream(0);
            applyStimulus(100, 100, 100, 200, cyc);
            for (int q = 0; q < 4; q++) begin
                w = int'(vecs[v].ppos[q]) / WB;
                b = int'(vecs[v].ppos[q]) % WB;
                if (w < txGot.size())
                    checkSignal($sformatf("vec%0d_probe%0d", v, q), DW'(txGot[w].data[8*b +: 8]), DW'(vecs[v].pval[q]));
                else
                    checkSignal($sformatf("vec%0d_missing_word", v), DW'(txGot.size()), DW'(w + 1));
            end
        end

        // Shared word: A ends at byte 20 of word 1, B starts at block 4 in the same word
        clearAll();
        hdrA = $urandom; hdrB = $urandom;
        addPkt(85, 0, 80, hdrA, 1, 0);
        addPkt(100, 4, 2, hdrB, 1, 0);
        addPkt(30, 0, 0, $urandom, 1, 0);
        buildStream(1);
        nWords = rxWords.size();
        applyStimulus(100, 100, 100, 100, cyc);
        checkSignal("shared_B_byte34", DW'(txGot[1].data[8*34 +: 8]), DW'(hdrB[7:0]));
        checkSignal("shared_A_byte16", DW'(txGot[1].data[8*16 +: 8]), DW'(hdrA[7:0]));
        checkSignal("full_throughput", DW'(cyc <= nWords + 2), DW'(1));

        // SOP word waits 5 cycles without a header
        clearAll();
        addPkt(100, 1, 10, $urandom, 1, 0);
        buildStream(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rx_data = rxWords[0].data; rx_sop = rxWords[0].sop; rx_eop = rxWords[0].eop;
            rx_sop_pos = rxWords[0].sp; rx_eop_pos = rxWords[0].ep; rx_src_rdy = 1'b1;
            hdr_src_rdy = 1'b0; tx_dst_rdy = 1'b1;
            #4;
            checkSignal("stall_rx_dst_rdy", DW'(rx_dst_rdy), DW'(0));
            checkSignal("stall_hdr_dst_rdy", DW'(hdr_dst_rdy), DW'(0));
        end
        rxActive = 1;
        applyStimulus(100, 100, 100, 200, cyc);

        // Reset mid-packet, then stray continuation word and fresh traffic
        clearAll();
        addPkt(128, 0, 70, $urandom, 1, 0);
        buildStream(1);
        stray = rxWords[1];
        @(negedge clk);
        rx_data = rxWords[0].data; rx_sop = 1'b1; rx_eop = 1'b0; rx_sop_pos = 3'd0; rx_eop_pos = rxWords[0].ep;
        rx_src_rdy = 1'b1; hdr_data = hdrQ[0].hdr; hdr_offset = 10'(hdrQ[0].off); hdr_en = 1'b1;
        hdr_src_rdy = 1'b1; tx_dst_rdy = 1'b0;
        #4;
        checkSignal("accept_rx", DW'(rx_dst_rdy), DW'(1));
        checkSignal("accept_hdr", DW'(hdr_dst_rdy), DW'(1));
        @(negedge clk);
        #1;
        checkSignal("latency_1cycle", DW'(tx_src_rdy), DW'(1));
        checkSignal("latency_data", tx_data, expWords[0].data);
        reset = 1'b1;
        #1;
        checkSignal("midreset_tx_src_rdy", DW'(tx_src_rdy), DW'(0));
        checkSignal("midreset_hdr_dst_rdy", DW'(hdr_dst_rdy), DW'(0));
        checkSignal("midreset_rx_dst_rdy", DW'(rx_dst_rdy), DW'(0));
        @(negedge clk);
        reset = 1'b0; rx_src_rdy = 1'b0; hdr_src_rdy = 1'b0;
        clearAll();
        rxWords.push_back(stray);
        expWords.push_back(stray);
        for (int i = 0; i < 4; i++) addPkt(128, 0, 1000, $urandom, 1, 0);
        for (int i = 0; i < 4; i++) addPkt($urandom_range(1, 200), $urandom_range(0, 7), 1000, $urandom, 1, 0);
        buildStream(1);
        applyStimulus(70, 70, 50, 5000, cyc);

        // Random traffic against the packet-level model
        clearAll();
        for (int i = 0; i < 40; i++) begin
            int len, off;
            len = $urandom_range(1, 200);
            off = ($urandom_range(4) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, len + 4);
            addPkt(len, $urandom_range(0, 7), off, $urandom, ($urandom_range(3) != 0), 0);
        end
        buildStream(1);
        applyStimulus(70, 60, 60, 20000, cyc);

        // Random HDR_EN=0 packets pass bit-identical
        clearAll();
        addPkt(200, 0, $urandom_range(0, 150), $urandom, 0, 0);
        addPkt(200, 3, 5, $urandom, 0, 0);
        buildStream(1);
        applyStimulus(80, 80, 80, 2000, cyc);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
